// File: rtl/gtech_outbuf_seq.sv
// Registered tristate pad driver with a sequenced output enable, a bus-turnaround
// guard, synchronised pad read-back and sticky contention detection.
module gtech_outbuf_seq #(
    parameter int WIDTH       = 8,
    parameter int TURN_CYC    = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] DATA_OUT,
    input  logic             OE_REQ,
    input  logic             CLR_ERR,
    output logic [WIDTH-1:0] PAD_OUT,
    input  logic [WIDTH-1:0] PAD_IN,
    output logic [WIDTH-1:0] DATA_IN,
    output logic             OE_ACK,
    output logic             TURN_BUSY,
    output logic             CONTENTION
);

    localparam int GW = (TURN_CYC < 1) ? 1 : $clog2(TURN_CYC + 1);

    typedef enum logic {
        ST_RELEASE = 1'b0,
        ST_DRIVE   = 1'b1
    } state_e;

    state_e                              state_q, state_d;
    logic [WIDTH-1:0]                    data_q, data_d;
    logic [GW-1:0]                       guard_q, guard_d;
    logic [SYNC_STAGES-1:0][WIDTH-1:0]   sync_q, sync_d;
    logic [SYNC_STAGES-1:0][WIDTH-1:0]   cmp_dat_q, cmp_dat_d;
    logic [SYNC_STAGES-1:0]              cmp_vld_q, cmp_vld_d;
    logic                                contention_q, contention_d;
    logic                                drive_en;
    logic                                mismatch;

    assign drive_en = (state_q == ST_DRIVE);

    // Drive sequencer: OE_REQ is only honoured once the turnaround guard has drained
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        guard_d = guard_q;
        case (state_q)
            ST_RELEASE: begin
                if (guard_q != '0) begin
                    guard_d = guard_q - GW'(1);
                end else if (OE_REQ) begin
                    state_d = ST_DRIVE;
                    data_d  = DATA_OUT;
                end
            end
            ST_DRIVE: begin
                if (OE_REQ) begin
                    data_d = DATA_OUT;
                end else begin
                    state_d = ST_RELEASE;
                    guard_d = GW'(TURN_CYC);
                end
            end
            default: begin
                state_d = ST_RELEASE;
            end
        endcase
    end

    // Read-back sync chain and the matching driven-data pipeline
    always_comb begin
        sync_d       = sync_q;
        cmp_dat_d    = cmp_dat_q;
        cmp_vld_d    = cmp_vld_q;
        sync_d[0]    = PAD_IN;
        cmp_dat_d[0] = data_q;
        cmp_vld_d[0] = drive_en;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i]    = sync_q[i-1];
            cmp_dat_d[i] = cmp_dat_q[i-1];
            cmp_vld_d[i] = cmp_vld_q[i-1];
        end
    end

    // Contention flag: a fresh mismatch beats a same-edge clear
    always_comb begin
        mismatch     = cmp_vld_q[SYNC_STAGES-1] &&
                       (sync_q[SYNC_STAGES-1] != cmp_dat_q[SYNC_STAGES-1]);
        contention_d = contention_q;
        if (mismatch) begin
            contention_d = 1'b1;
        end else if (CLR_ERR) begin
            contention_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_RELEASE;
            data_q       <= '0;
            guard_q      <= '0;
            sync_q       <= '0;
            cmp_dat_q    <= '0;
            cmp_vld_q    <= '0;
            contention_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            guard_q      <= guard_d;
            sync_q       <= sync_d;
            cmp_dat_q    <= cmp_dat_d;
            cmp_vld_q    <= cmp_vld_d;
            contention_q <= contention_d;
        end
    end

    // Outputs; the pads release as soon as reset clears the state register
    assign PAD_OUT    = drive_en ? data_q : {WIDTH{1'bz}};
    assign OE_ACK     = drive_en;
    assign TURN_BUSY  = (guard_q != '0);
    assign DATA_IN    = sync_q[SYNC_STAGES-1];
    assign CONTENTION = contention_q;

endmodule
